hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
// - Central pipeline-control unit. Drives the lock (hold) and flush (bubble) inputs of the PC and of every stage register
//   (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Detects load-use hazards, EX-stage redirects (taken branch/jump), fixed-latency mul/div occupancy and memory wait.
// - Keeps a saturating stall-cycle performance counter.
// PARAMETERS
// - MULDIV_LATENCY  4   EX cycles a mul/div occupies; legal range >= 1
// - REG_ADDR_W      5   register-index width
// - PERF_W          32  width of stall_cycles
// PORTS
// clk            in   1           clock; all state updates on posedge
// rst            in   1           synchronous, active-low reset (0 = reset)
// id_rs1, id_rs2 in   REG_ADDR_W  source registers of the instruction in ID
// id_rs1_used    in   1           ID instruction reads rs1
// id_rs2_used    in   1           ID instruction reads rs2
// ex_memread     in   1           instruction in EX is a load
// ex_rd          in   REG_ADDR_W  destination register of the instruction in EX
// ex_redirect    in   1           EX resolved a taken branch/jump this cycle
// ex_muldiv      in   1           EX holds a mul/div that has not started yet
// mem_busy       in   1           data memory wait-state request
// pc_lock        out  1           hold PC
// ifid_lock      out  1           hold IF/ID register
// idex_lock      out  1           hold ID/EX register
// exmem_lock     out  1           hold EX/MEM register
// memwb_lock     out  1           hold MEM/WB register
// ifid_flush     out  1           clear IF/ID register to NOP
// idex_flush     out  1           clear ID/EX register to NOP
// exmem_flush    out  1           clear EX/MEM register to NOP
// stall_cycles   out  PERF_W      count of cycles with pc_lock=1; saturates at all-ones
// BEHAVIOUR
// - Outputs are Mealy (combinational from state + inputs); zero latency.
//   Stage registers sample them on the same edge. Flush wins over lock inside a stage register.
// - States: RUN, MULDIV. Counter cnt is wide enough to hold MULDIV_LATENCY-1.
// - Reset (rst=0 at posedge): state=RUN, cnt=0, stall_cycles=0.
//   While rst=0, all locks=0 and all flushes=1.
// - Priority, highest first. Exactly one rule applies per cycle:
//   1. mem_busy=1, any state: every *_lock=1, every flush=0. State and cnt hold. stall_cycles still counts.
//   2. MULDIV: pc/ifid/idex lock=1; exmem_flush=1 (bubble to MEM); memwb proceeds.
//      - cnt!=0: cnt decrements.
//      - cnt==0: this is the final stall cycle; next state RUN.
//   3. RUN, ex_redirect=1: ifid_flush=1, idex_flush=1; no locks.
//      Overrides load-use and ex_muldiv on the same cycle, because the ID instruction is wrong-path.
//   4. RUN, ex_muldiv=1: the same outputs as rule 2 apply this cycle.
//      - MULDIV_LATENCY=1: stay in RUN.
//      - Otherwise: next state MULDIV, cnt=MULDIV_LATENCY-2.
//      - Total pc_lock cycles = MULDIV_LATENCY.
//   5. RUN, load-use: ex_memread && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
//      Outputs: pc_lock=1, ifid_lock=1, idex_flush=1, for exactly one cycle.
//      The following cycle is handled by MEM->EX forwarding.
//   6. Otherwise: all locks=0, all flushes=0.
// - rd=x0 never creates a hazard. An unused source never creates a hazard.
// - Rule 1 arriving mid-MULDIV freezes the countdown; it resumes when mem_busy drops.
// - stall_cycles increments on every posedge with rst=1 and pc_lock=1. It holds at all-ones.
// - rst=0 mid-MULDIV aborts the stall immediately: the next state is RUN.
// STRUCTURE
// - Shared include src/include/HazardSpec.v holds:
//   - state encodings `HZ_RUN, `HZ_MULDIV;
//   - `REGADDR_BUS;
//   - default `MULDIV_LATENCY.
// - One natural sub-module: hazard_stall_timer.
//   - Ports: load, load_value, freeze, zero flag.
//   - Holds cnt and the MULDIV exit condition.
// - Load-use comparison and the priority mux stay inline.
// TESTING
// - Reset: rst=0 for 2 cycles -> all flushes=1, locks=0, stall_cycles=0. After release with idle inputs -> all outputs 0.
// - Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle with pc_lock=ifid_lock=idex_flush=1.
//   - Same stimulus with ex_rd=0 -> no stall.
//   - Same stimulus with id_rs2_used=0 -> no stall.
// - Redirect beats load-use: ex_redirect=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_lock=0.
// - Mul/div: ex_muldiv=1 for one cycle, MULDIV_LATENCY=4 -> pc_lock=1 and exmem_flush=1 for exactly 4 cycles.
//   Then the pipeline runs and stall_cycles=4.
// - Mem wait mid-MULDIV: mem_busy=1 for 3 cycles, starting in the 2nd stall cycle -> all locks=1, flushes=0.
//   The stall totals 7 cycles.
// - Saturation and abort: PERF_W=4 with 20 stall cycles -> stall_cycles=15.
//   Separately, rst=0 in the 2nd MULDIV cycle -> state RUN; after release, a mul/div stall restarts from full latency.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// default parameter values and the countdown width helper.
package hazard_pkg;

    typedef enum logic {
        HZ_RUN    = 1'b0,
        HZ_MULDIV = 1'b1
    } hz_state_t;

    localparam int DEFAULT_MULDIV_LATENCY = 4;
    localparam int DEFAULT_REG_ADDR_W     = 5;
    localparam int DEFAULT_PERF_W         = 32;

    // Bits needed to hold MULDIV_LATENCY-1 (at least one bit).
    function automatic int cnt_width(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/hazard_stall_timer.sv
// Mul/div occupancy countdown. Loaded when a mul/div enters EX, counts down
// once per unfrozen cycle, and flags zero on the final stall cycle.
module hazard_stall_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             freeze,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;

    // Countdown register: load has priority, freeze holds, stops at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_value;
        end else if (!freeze && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline control: drives lock/flush of PC and stage registers from
// load-use, EX redirect, mul/div occupancy and memory wait, and counts
// stall cycles with saturation. Outputs are combinational (Mealy).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
    parameter int REG_ADDR_W     = DEFAULT_REG_ADDR_W,
    parameter int PERF_W         = DEFAULT_PERF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_redirect,
    input  logic                  ex_muldiv,
    input  logic                  mem_busy,
    output logic                  pc_lock,
    output logic                  ifid_lock,
    output logic                  idex_lock,
    output logic                  exmem_lock,
    output logic                  memwb_lock,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic [PERF_W-1:0]     stall_cycles
);

    localparam int CNT_W    = cnt_width(MULDIV_LATENCY);
    localparam int LOAD_VAL = (MULDIV_LATENCY > 1) ? (MULDIV_LATENCY - 2) : 0;

    hz_state_t         state_reg, state_next;
    logic              timer_load;
    logic              timer_freeze;
    logic              timer_zero;
    logic              load_use;
    logic [PERF_W-1:0] stall_cycles_reg;

    // x0 is never written, and an unused source cannot depend on the load.
    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // Countdown only advances while actually stalling for mul/div and not
    // frozen by a memory wait.
    assign timer_freeze = mem_busy || (state_reg != HZ_MULDIV);

    hazard_stall_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (CNT_W'(LOAD_VAL)),
        .freeze     (timer_freeze),
        .zero       (timer_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= HZ_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Priority mux: exactly one rule drives the controls each cycle.
    always_comb begin
        state_next  = state_reg;
        timer_load  = 1'b0;
        pc_lock     = 1'b0;
        ifid_lock   = 1'b0;
        idex_lock   = 1'b0;
        exmem_lock  = 1'b0;
        memwb_lock  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!rst) begin
            state_next  = HZ_RUN;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_busy) begin
            pc_lock    = 1'b1;
            ifid_lock  = 1'b1;
            idex_lock  = 1'b1;
            exmem_lock = 1'b1;
            memwb_lock = 1'b1;
        end else if (state_reg == HZ_MULDIV) begin
            pc_lock     = 1'b1;
            ifid_lock   = 1'b1;
            idex_lock   = 1'b1;
            exmem_flush = 1'b1;
            if (timer_zero) begin
                state_next = HZ_RUN;
            end
        end else if (ex_redirect) begin
            // ID holds a wrong-path instruction, so its hazards are moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_muldiv) begin
            pc_lock     = 1'b1;
            ifid_lock   = 1'b1;
            idex_lock   = 1'b1;
            exmem_flush = 1'b1;
            if (MULDIV_LATENCY > 1) begin
                state_next = HZ_MULDIV;
                timer_load = 1'b1;
            end
        end else if (load_use) begin
            pc_lock    = 1'b1;
            ifid_lock  = 1'b1;
            idex_flush = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_reg <= '0;
        end else if (pc_lock && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule
